// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the error-response state type used by
// the local SRAM subordinates.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE   = 2'd0,
        ERR_FIRST  = 2'd1,
        ERR_SECOND = 2'd2
    } err_state_e;

endpackage

// File: rtl/ahb_byte_lanes.sv
// Decodes an AHB transfer size and low address bits into 32-bit byte lanes,
// flagging sizes above a word and misaligned halves/words as illegal.
module ahb_byte_lanes
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] lanes,
    output logic       illegal
);

    always_comb begin
        lanes   = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                lanes   = addr_lo[1] ? 4'b1100 : 4'b0011;
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                lanes   = 4'b1111;
                illegal = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
        // An illegal transfer must never enable any lane downstream.
        if (illegal) begin
            lanes = 4'b0000;
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite subordinate for a single-port synchronous SRAM: zero-wait reads,
// writes posted through a one-entry buffer with read forwarding.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 18
)
(
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [31:0]       hwdata,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic              sram_cen,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    logic [3:0]        req_lanes;
    logic              req_illegal;
    logic [ADDR_W-1:0] req_addr;
    logic              accept;
    logic              legal_accept;
    logic              illegal_accept;
    logic              legal_read;

    logic              ph_valid_reg;
    logic              ph_write_reg;
    logic [ADDR_W-1:0] ph_addr_reg;
    logic [3:0]        ph_lanes_reg;

    logic              wb_valid_reg;
    logic [ADDR_W-1:0] wb_addr_reg;
    logic [3:0]        wb_lanes_reg;
    logic [31:0]       wb_data_reg;

    logic              wr_capture;
    logic              rd_dphase;
    logic              addr_hit;
    logic              drain;

    err_state_e        state_reg;
    err_state_e        state_next;

    logic              unused_inputs;
    assign unused_inputs = ^{haddr[31:ADDR_W+2], hburst, hprot};

    ahb_byte_lanes u_lanes (
        .size    (hsize),
        .addr_lo (haddr[1:0]),
        .lanes   (req_lanes),
        .illegal (req_illegal)
    );

    assign req_addr       = haddr[ADDR_W+1:2];
    assign accept         = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    assign legal_accept   = accept & ~req_illegal;
    assign illegal_accept = accept & req_illegal;
    assign legal_read     = legal_accept & ~hwrite;

    assign wr_capture = ph_valid_reg & ph_write_reg & hready;
    assign rd_dphase  = ph_valid_reg & ~ph_write_reg;
    assign addr_hit   = wb_valid_reg & (wb_addr_reg == ph_addr_reg);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            ph_valid_reg <= 1'b0;
            ph_write_reg <= 1'b0;
            ph_addr_reg  <= '0;
            ph_lanes_reg <= 4'b0000;
        end else if (hready) begin
            ph_valid_reg <= legal_accept;
            ph_write_reg <= hwrite;
            ph_addr_reg  <= req_addr;
            ph_lanes_reg <= req_lanes;
        end
    end

    // Reads own the port; the buffered write only retires on a cycle with no
    // read. The port is held quiet during reset so a buffered write is dropped.
    always_comb begin
        sram_cen  = 1'b0;
        sram_wen  = 4'b0000;
        sram_addr = wb_addr_reg;
        sram_din  = wb_data_reg;
        drain     = 1'b0;
        if (!hreset) begin
            if (legal_read) begin
                sram_cen  = 1'b1;
                sram_addr = req_addr;
            end else if (wb_valid_reg) begin
                sram_cen = 1'b1;
                sram_wen = wb_lanes_reg;
                drain    = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_lanes_reg <= 4'b0000;
        end else if (wr_capture) begin
            wb_valid_reg <= 1'b1;
            wb_addr_reg  <= ph_addr_reg;
            wb_lanes_reg <= ph_lanes_reg;
        end else if (drain) begin
            wb_valid_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        always_ff @(posedge hclk) begin
            if (wr_capture && ph_lanes_reg[gi]) begin
                wb_data_reg[gi*8 +: 8] <= hwdata[gi*8 +: 8];
            end
        end

        // Bytes still waiting in the buffer are newer than the SRAM copy.
        assign hrdata[gi*8 +: 8] = !rd_dphase ? 8'h00 :
                                   (addr_hit && wb_lanes_reg[gi]) ? wb_data_reg[gi*8 +: 8] :
                                   sram_dout[gi*8 +: 8];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ERR_IDLE:   if (illegal_accept) state_next = ERR_FIRST;
            ERR_FIRST:  state_next = ERR_SECOND;
            ERR_SECOND: state_next = illegal_accept ? ERR_FIRST : ERR_IDLE;
            default:    state_next = ERR_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg <= ERR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign hreadyout = (state_reg != ERR_FIRST);
    assign hresp     = (state_reg == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;

    // The upstream master never issues back-to-back writes, so the buffer has
    // always drained by the next write's data phase; overwriting it would lose data.
    assert property (@(posedge hclk) disable iff (hreset) wr_capture |-> !wb_valid_reg);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave against a flat byte-lane memory model.
module tb_ahb_sram_slave;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              hclk = 1'b0;
    logic              hreset, hsel, hwrite, hready, hreadyout, hresp;
    logic [31:0]       haddr, hwdata, hrdata;
    logic [1:0]        htrans;
    logic [2:0]        hsize, hburst;
    logic [3:0]        hprot;
    logic              sram_cen;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din, sram_dout;

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    ahb_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hburst(hburst), .hprot(hprot),
        .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // SRAM part: one-cycle read latency, byte write enables.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge hclk) begin
        if (sram_cen) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wen[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
            sram_dout <= sram_mem[sram_addr];
        end
    end

    logic [ADDR_W-1:0] wlog_addr [$];
    logic [3:0]        wlog_wen  [$];
    logic [31:0]       wlog_din  [$];
    always @(posedge hclk) begin
        if (sram_cen && sram_wen != 4'b0000) begin
            wlog_addr.push_back(sram_addr);
            wlog_wen.push_back(sram_wen);
            wlog_din.push_back(sram_din);
        end
    end

    // Reference: architectural memory contents in bus order.
    logic [31:0] ref_mem [int];

    int vectors     = 0;
    int miscompares = 0;

    logic              s_rdy, s_resp, s_cen;
    logic [31:0]       s_rdata;
    logic [3:0]        s_wen;
    logic [ADDR_W-1:0] s_addr;

    function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] lo);
        case (sz)
            3'd0:    return 4'b0001 << lo;
            3'd1:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int w;
        w = int'(a[ADDR_W+1:2]);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int w;
        logic [31:0] v;
        logic [3:0] m;
        w = int'(a[ADDR_W+1:2]);
        m = lane_mask(sz, a[1:0]);
        v = ref_read(a);
        for (int b = 0; b < 4; b++) if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[w] = v;
    endtask

    // One bus cycle: drive, sample mid-cycle, advance past the next edge.
    task automatic cyc(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [31:0] wdata, input logic rst);
        hsel   = (trans != 2'd0);
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        hsize  = sz;
        hwdata = wdata;
        hreset = rst;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        @(negedge hclk);
        s_rdy   = hreadyout;
        s_resp  = hresp;
        s_rdata = hrdata;
        s_cen   = sram_cen;
        s_wen   = sram_wen;
        s_addr  = sram_addr;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input logic [31:0] wdata);
        cyc(2'd0, 1'b0, 32'h0, 3'd2, wdata, 1'b0);
    endtask

    task automatic prime_word(input logic [31:0] a, input logic [31:0] d);
        cyc(2'd2, 1'b1, a, 3'd2, $urandom, 1'b0);
        idle(d);
        ref_write(a, 3'd2, d);
    endtask

    task automatic test_reset;
        cyc(2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b1);
        cyc(2'd0, 1'b0, 32'h0, 3'd2, 32'h0, 1'b1);
        vectors++;
        if (s_cen !== 1'b0) begin miscompares++; $display("FAIL reset_cen_in_reset: got %b expected 0", s_cen); end
        idle(32'h0);
        vectors++;
        if ({s_rdy, s_resp} !== 2'b10) begin miscompares++; $display("FAIL reset_resp: got rdy/resp %b expected 10", {s_rdy, s_resp}); end
        vectors++;
        if (s_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_hrdata: got %h expected 00000000", s_rdata); end
        vectors++;
        if ({s_cen, s_wen} !== 5'b0) begin miscompares++; $display("FAIL reset_sram: got cen/wen %b expected 00000", {s_cen, s_wen}); end
    endtask

    task automatic test_write_read;
        wlog_addr.delete(); wlog_wen.delete(); wlog_din.delete();
        cyc(2'd2, 1'b1, 32'h100, 3'd2, $urandom, 1'b0);
        ref_write(32'h100, 3'd2, 32'hDEADBEEF);
        idle(32'hDEADBEEF);
        vectors++;
        if ({s_rdy, s_cen} !== 2'b10) begin miscompares++; $display("FAIL wr_dphase: got rdy/cen %b expected 10", {s_rdy, s_cen}); end
        idle($urandom);
        vectors++;
        if ({s_cen, s_wen, s_addr} !== {1'b1, 4'b1111, 18'h40}) begin
            miscompares++; $display("FAIL wr_drain: got cen %b wen %b addr %h expected 1 1111 00040", s_cen, s_wen, s_addr);
        end
        cyc(2'd2, 1'b0, 32'h100, 3'd2, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if (s_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_readback: got %h expected deadbeef", s_rdata); end
        vectors++;
        if (wlog_addr.size() != 1) begin
            miscompares++; $display("FAIL wr_count: got %0d sram writes expected 1", wlog_addr.size());
        end else if ({wlog_addr[0], wlog_wen[0], wlog_din[0]} !== {18'h40, 4'hF, 32'hDEADBEEF}) begin
            miscompares++; $display("FAIL wr_log: got addr %h wen %b din %h expected 00040 1111 deadbeef", wlog_addr[0], wlog_wen[0], wlog_din[0]);
        end
    endtask

    task automatic test_forward;
        logic [31:0] d;
        prime_word(32'h200, 32'h11223344);
        idle($urandom);
        d = {8'hAA, 24'($urandom)};
        cyc(2'd2, 1'b1, 32'h203, 3'd0, $urandom, 1'b0);
        ref_write(32'h203, 3'd0, d);
        cyc(2'd2, 1'b0, 32'h200, 3'd2, d, 1'b0);
        vectors++;
        if ({s_rdy, s_cen, s_wen} !== 6'b110000) begin miscompares++; $display("FAIL fwd_rd_port: got rdy/cen/wen %b expected 110000", {s_rdy, s_cen, s_wen}); end
        idle($urandom);
        vectors++;
        if (s_rdata !== 32'hAA223344 || s_rdy !== 1'b1) begin miscompares++; $display("FAIL fwd_data: got %h rdy %b expected aa223344 rdy 1", s_rdata, s_rdy); end
        vectors++;
        if ({s_cen, s_wen} !== 5'b11000) begin miscompares++; $display("FAIL fwd_drain: got cen/wen %b expected 11000", {s_cen, s_wen}); end
        cyc(2'd2, 1'b0, 32'h200, 3'd2, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if (s_rdata !== ref_read(32'h200)) begin miscompares++; $display("FAIL fwd_sram: got %h expected %h", s_rdata, ref_read(32'h200)); end
    endtask

    task automatic test_back_to_back;
        logic pend_wr, pend_rd, prev_wr;
        logic [31:0] pend_wd, pend_exp, a, wd_now, nd;
        logic [2:0] sz;
        logic [1:0] lo;
        int kind, nwrites;
        for (int w = 0; w < 16; w++) prime_word(32'hC00 + 32'(w * 4), $urandom);
        idle($urandom);
        idle($urandom);
        wlog_addr.delete(); wlog_wen.delete(); wlog_din.delete();
        nwrites = 0; pend_wr = 1'b0; pend_rd = 1'b0; prev_wr = 1'b0; pend_wd = 32'h0; pend_exp = 32'h0;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            if (prev_wr && kind >= 3) kind = 1;
            sz = 3'($urandom_range(0, 2));
            lo = (sz == 3'd0) ? 2'($urandom_range(0, 3)) : (sz == 3'd1) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
            a  = 32'hC00 + 32'($urandom_range(0, 15) * 4) + 32'(lo);
            wd_now = pend_wr ? pend_wd : $urandom;
            if (kind == 0) cyc(2'($urandom_range(0, 1)), 1'($urandom), a, sz, wd_now, 1'b0);
            else if (kind <= 2) cyc(2'($urandom_range(2, 3)), 1'b0, a, sz, wd_now, 1'b0);
            else cyc(2'($urandom_range(2, 3)), 1'b1, a, sz, wd_now, 1'b0);
            vectors++;
            if ({s_rdy, s_resp} !== 2'b10) begin miscompares++; $display("FAIL b2b_ready op %0d: got rdy/resp %b expected 10", i, {s_rdy, s_resp}); end
            if (pend_rd) begin
                vectors++;
                if (s_rdata !== pend_exp) begin miscompares++; $display("FAIL b2b_read op %0d: got %h expected %h", i, s_rdata, pend_exp); end
            end
            pend_rd = (kind == 1 || kind == 2);
            if (pend_rd) pend_exp = ref_read(a);
            prev_wr = (kind >= 3);
            pend_wr = prev_wr;
            if (prev_wr) begin
                nd = $urandom;
                ref_write(a, sz, nd);
                pend_wd = nd;
                nwrites++;
            end
        end
        idle(pend_wr ? pend_wd : $urandom);
        if (pend_rd) begin
            vectors++;
            if (s_rdata !== pend_exp) begin miscompares++; $display("FAIL b2b_read last: got %h expected %h", s_rdata, pend_exp); end
        end
        idle($urandom);
        idle($urandom);
        vectors++;
        if (wlog_addr.size() != nwrites) begin miscompares++; $display("FAIL b2b_write_count: got %0d expected %0d", wlog_addr.size(), nwrites); end
        for (int w = 0; w < 16; w++) begin
            vectors++;
            if (sram_mem[18'h300 + 18'(w)] !== ref_read(32'hC00 + 32'(w * 4))) begin
                miscompares++; $display("FAIL b2b_sram word %0d: got %h expected %h", w, sram_mem[18'h300 + 18'(w)], ref_read(32'hC00 + 32'(w * 4)));
            end
        end
    endtask

    task automatic test_error;
        logic [2:0] sz;
        logic [1:0] lo;
        int t;
        wlog_addr.delete(); wlog_wen.delete(); wlog_din.delete();
        cyc(2'd2, 1'b0, 32'h102, 3'd2, $urandom, 1'b0);
        vectors++;
        if (s_cen !== 1'b0) begin miscompares++; $display("FAIL err_no_access: got cen %b expected 0", s_cen); end
        idle($urandom);
        vectors++;
        if ({s_rdy, s_resp, s_cen} !== 3'b010) begin miscompares++; $display("FAIL err_cycle1: got rdy/resp/cen %b expected 010", {s_rdy, s_resp, s_cen}); end
        idle($urandom);
        vectors++;
        if ({s_rdy, s_resp, s_cen} !== 3'b110) begin miscompares++; $display("FAIL err_cycle2: got rdy/resp/cen %b expected 110", {s_rdy, s_resp, s_cen}); end
        cyc(2'd2, 1'b0, 32'h100, 3'd2, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if ({s_rdy, s_resp} !== 2'b10 || s_rdata !== ref_read(32'h100)) begin
            miscompares++; $display("FAIL err_recover: got rdy/resp %b data %h expected 10 %h", {s_rdy, s_resp}, s_rdata, ref_read(32'h100));
        end
        for (int k = 0; k < 6; k++) begin
            t = $urandom_range(0, 2);
            if (t == 0) begin sz = 3'($urandom_range(3, 7)); lo = 2'($urandom); end
            else if (t == 1) begin sz = 3'd1; lo = 2'($urandom_range(0, 1) * 2 + 1); end
            else begin sz = 3'd2; lo = 2'($urandom_range(1, 3)); end
            cyc(2'd2, 1'($urandom), 32'h100 + 32'(lo), sz, $urandom, 1'b0);
            idle($urandom);
            vectors++;
            if ({s_rdy, s_resp, s_cen} !== 3'b010) begin miscompares++; $display("FAIL err_rand1 %0d: got rdy/resp/cen %b expected 010", k, {s_rdy, s_resp, s_cen}); end
            if (k % 2 == 1) begin
                cyc(2'd2, 1'b0, 32'h100 + 32'(lo), sz, $urandom, 1'b0);
                vectors++;
                if ({s_rdy, s_resp, s_cen} !== 3'b110) begin miscompares++; $display("FAIL err_rand_again %0d: got rdy/resp/cen %b expected 110", k, {s_rdy, s_resp, s_cen}); end
                idle($urandom);
                vectors++;
                if ({s_rdy, s_resp} !== 2'b01) begin miscompares++; $display("FAIL err_rand_reentry %0d: got rdy/resp %b expected 01", k, {s_rdy, s_resp}); end
            end
            idle($urandom);
            vectors++;
            if ({s_rdy, s_resp, s_cen} !== 3'b110) begin miscompares++; $display("FAIL err_rand2 %0d: got rdy/resp/cen %b expected 110", k, {s_rdy, s_resp, s_cen}); end
        end
        idle($urandom);
        vectors++;
        if (wlog_addr.size() != 0) begin miscompares++; $display("FAIL err_no_write: got %0d sram writes expected 0", wlog_addr.size()); end
    endtask

    task automatic test_half;
        logic [31:0] d;
        prime_word(32'h004, $urandom);
        idle($urandom);
        wlog_addr.delete(); wlog_wen.delete(); wlog_din.delete();
        d = {16'h1234, 16'($urandom)};
        cyc(2'd2, 1'b1, 32'h006, 3'd1, $urandom, 1'b0);
        ref_write(32'h006, 3'd1, d);
        idle(d);
        idle($urandom);
        vectors++;
        if ({s_cen, s_wen, s_addr} !== {1'b1, 4'b1100, 18'h1}) begin
            miscompares++; $display("FAIL half_drain: got cen %b wen %b addr %h expected 1 1100 00001", s_cen, s_wen, s_addr);
        end
        cyc(2'd2, 1'b0, 32'h004, 3'd2, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if (s_rdata[31:16] !== 16'h1234 || s_rdata !== ref_read(32'h004)) begin
            miscompares++; $display("FAIL half_readback: got %h expected %h", s_rdata, ref_read(32'h004));
        end
        cyc(2'd2, 1'b0, 32'h006, 3'd1, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if (s_rdata !== ref_read(32'h004)) begin miscompares++; $display("FAIL half_read_half: got %h expected %h", s_rdata, ref_read(32'h004)); end
    endtask

    task automatic test_reset_mid;
        prime_word(32'h020, 32'h5A5A0F0F);
        idle($urandom);
        idle($urandom);
        wlog_addr.delete(); wlog_wen.delete(); wlog_din.delete();
        cyc(2'd2, 1'b1, 32'h020, 3'd2, $urandom, 1'b0);
        idle(32'hFFFF0000);
        cyc(2'd0, 1'b0, 32'h0, 3'd2, $urandom, 1'b1);
        vectors++;
        if (s_cen !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_reset: got cen %b expected 0", s_cen); end
        idle($urandom);
        vectors++;
        if ({s_cen, s_rdy, s_resp} !== 3'b010) begin miscompares++; $display("FAIL rstmid_after: got cen/rdy/resp %b expected 010", {s_cen, s_rdy, s_resp}); end
        idle($urandom);
        idle($urandom);
        vectors++;
        if (wlog_addr.size() != 0 || sram_mem[18'h8] !== 32'h5A5A0F0F) begin
            miscompares++; $display("FAIL rstmid_dropped: got %0d writes word %h expected 0 5a5a0f0f", wlog_addr.size(), sram_mem[18'h8]);
        end
        cyc(2'd2, 1'b0, 32'h020, 3'd2, $urandom, 1'b0);
        idle($urandom);
        vectors++;
        if (s_rdata !== 32'h5A5A0F0F) begin miscompares++; $display("FAIL rstmid_read: got %h expected 5a5a0f0f", s_rdata); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_back_to_back();
        test_error();
        test_half();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
